// File: rtl/load_store_unit_if.sv
// Core-side request/response and Data_Memory bus for the load/store unit.
// The unit itself connects through the slave modport.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
           mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
           mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: word-only memory accesses, byte/halfword stores by
// read-modify-write, lane extraction for loads, alignment/range trapping.
//
// state    | meaning
// IDLE     | ready for a request
// LOAD     | reading addressed word, extracting lane
// RMW_RD   | reading word to merge byte/halfword store data
// WRITE    | mem_we high, full or merged word on mem_wd
// RESP     | one-cycle response pulse
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input logic              clk_i,
  input logic              rst_i,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        flt_q, flt_d;

  logic        acc_legal;
  logic        acc_mis;
  logic        acc_oor;

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  k);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {k, 3'b000});
    h = 16'(w >> {k[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  k);
    logic [31:0] m;
    logic [31:0] d;
    if (f3[1:0] == 2'b00) begin
      m = 32'h0000_00FF << {k, 3'b000};
      d = {4{wd[7:0]}};
    end else begin
      m = 32'h0000_FFFF << {k[1], 4'b0000};
      d = {2{wd[15:0]}};
    end
    return (w & ~m) | (d & m);
  endfunction

  // Misalignment covers illegal funct3 for the direction as well.
  always_comb begin
    if (bus.req_we)
      acc_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    else
      acc_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
    acc_mis = !acc_legal ||
              ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    acc_oor = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      flt_q    <= flt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    flt_d    = flt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          mis_d    = acc_mis;
          flt_d    = !acc_mis && acc_oor;
          if (acc_mis || acc_oor)
            state_d = S_RESP;
          else if (!bus.req_we)
            state_d = S_LOAD;
          else if (bus.req_funct3 == 3'b010)
            state_d = S_WRITE;
          else
            state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_extract(bus.mem_rd, funct3_q, addr_q[1:0]);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wdata_d = store_merge(bus.mem_rd, wdata_q, funct3_q, addr_q[1:0]);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        flt_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response fields are forced to zero outside the RESP pulse.
  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.rsp_valid      = (state_q == S_RESP);
  assign bus.rsp_rdata      = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_misaligned = bus.rsp_valid & mis_q;
  assign bus.rsp_fault      = bus.rsp_valid & flt_q;
  assign bus.mem_we         = (state_q == S_WRITE);
  assign bus.mem_a          = {addr_q[31:2], 2'b00};
  assign bus.mem_wd         = bus.mem_we ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model
// with a word-array memory and queues of expected responses and writes.
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Data_Memory stand-in
  logic [31:0] tb_mem  [256] = '{default: '0};
  logic [31:0] ref_mem [256] = '{default: '0};
  assign bus.mem_rd = tb_mem[bus.mem_a[9:2]];
  always @(posedge clk_i) if (bus.mem_we) tb_mem[bus.mem_a[9:2]] <= bus.mem_wd;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int cyc; logic [31:0] rdata; logic mis; logic flt;} rsp_t;
  typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t er;
  wr_t  ew;
  bit   chk_en = 1'b0;

  always @(negedge clk_i) begin
    if (chk_en) begin
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        er = rsp_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, er.rdata);
        chk("rsp_flags", {30'b0, bus.rsp_misaligned, bus.rsp_fault}, {30'b0, er.mis, er.flt});
      end else begin
        chk("rsp_quiet", {29'b0, bus.rsp_valid, bus.rsp_misaligned, bus.rsp_fault}, 32'd0);
        chk("rsp_rdata_quiet", bus.rsp_rdata, 32'd0);
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        ew = wr_q.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'd1);
        chk("mem_a", bus.mem_a, ew.a);
        chk("mem_wd", bus.mem_wd, ew.d);
      end else begin
        chk("mem_we_quiet", 32'(bus.mem_we), 32'd0);
      end
    end
  end

  logic [31:0] last_rd;
  logic        last_mis, last_flt;

  // Transaction-level model: classify, apply to ref_mem, queue expectations.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int acc, output int lat);
    int size, sh;
    logic [31:0] w, m, v;
    bit legal;
    legal    = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size     = 1 << f3[1:0];
    last_mis = !legal || ((addr & 32'(size - 1)) != 0);
    last_flt = !last_mis && ((addr >> 2) >= 256);
    last_rd  = '0;
    if (last_mis || last_flt) begin
      lat = 1;
    end else begin
      w  = ref_mem[addr[9:2]];
      sh = 8 * int'(addr[1:0]);
      m  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!we) begin
        v = (w >> sh) & m;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~m;
        last_rd = v;
        lat = 2;
      end else begin
        m = m << sh;
        ref_mem[addr[9:2]] = (w & ~m) | ((wd << sh) & m);
        lat = (size == 4) ? 2 : 3;
        wr_q.push_back('{acc + lat - 2, {addr[31:2], 2'b00}, ref_mem[addr[9:2]]});
      end
    end
    rsp_q.push_back('{acc + lat - 1, last_rd, last_mis, last_flt});
  endtask

  task automatic junk();
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom_range(0, 32'h3FF);
    bus.req_wdata  = $urandom;
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int acc, lat, n;
    @(negedge clk_i);
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk_i);
    #1;
    acc = cyc;
    model(we, f3, addr, wd, acc, lat);
    junk();
    forever begin
      @(negedge clk_i);
      if (cyc >= acc + lat - 1) break;
      junk();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp"}, {29'b0, bus.rsp_valid, bus.rsp_misaligned, bus.rsp_fault}, 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_a"}, bus.mem_a, 32'd0);
    chk({tag, "_wd"}, bus.mem_wd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #1 rst_i = 1'b1;
    #1 chk_reset("reset");
    @(negedge clk_i);
    rst_i  = 1'b0;
    chk_en = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_mem", tb_mem[4], 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_lit", last_rd, 32'hDEADBEEF);

    do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h22, 32'h000000AB);
    chk("sb_mem", tb_mem[8], 32'h11AB3344);
    chk("sb_model", ref_mem[8], 32'h11AB3344);
    do_req(1'b0, 3'b000, 32'h22, 32'h0);
    chk("lb_lit", last_rd, 32'hFFFFFFAB);
    do_req(1'b0, 3'b100, 32'h22, 32'h0);
    chk("lbu_lit", last_rd, 32'h000000AB);

    do_req(1'b1, 3'b001, 32'h26, 32'h00008001);
    chk("sh_mem", tb_mem[9], 32'h80010000);
    do_req(1'b0, 3'b001, 32'h26, 32'h0);
    chk("lh_lit", last_rd, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h26, 32'h0);
    chk("lhu_lit", last_rd, 32'h00008001);

    do_req(1'b0, 3'b010, 32'h13, 32'h0);
    chk("lw13_mis", 32'(last_mis), 32'd1);
    do_req(1'b1, 3'b001, 32'h21, 32'h5555);
    chk("sh21_mis", 32'(last_mis), 32'd1);
    chk("sh21_mem", tb_mem[8], 32'h11AB3344);
    do_req(1'b0, 3'b011, 32'h20, 32'h0);
    chk("f3_011_mis", 32'(last_mis), 32'd1);

    do_req(1'b1, 3'b010, 32'h400, 32'h12345678);
    chk("oor_flt", 32'(last_flt), 32'd1);
    chk("oor_mem", tb_mem[0], 32'h0);
    do_req(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0);
    chk("lw3fc_lit", last_rd, 32'hCAFEF00D);

    // Reset while an SB is in its WRITE cycle
    @(negedge clk_i);
    chk_en = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h21;
    bus.req_wdata  = 32'h5A;
    @(posedge clk_i);
    #1 bus.req_valid = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rmw_write_we", 32'(bus.mem_we), 32'd1);
    #2 rst_i = 1'b1;
    #1 chk_reset("midrst");
    @(negedge clk_i);
    rst_i  = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("midrst_mem", tb_mem[8], 32'h11AB3344);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    chk("midrst_lw_lit", last_rd, 32'h11AB3344);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h400 + $urandom_range(0, 255);
      else             a = $urandom_range(0, 32'h3FF);
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    repeat (4) @(negedge clk_i);
    chk("queues_drained", 32'(rsp_q.size() + wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
